kfmmc_block_write_sequencer: RTL

//  Upstream stage of KFMMC_DRIVE. Converts a (start, 32-bit block address) request plus an
//  8-bit valid/ready byte stream into the drive's strobe protocol: address bytes 1-4, the

---
 rtl/kfmmc_block_write_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/kfmmc_block_write_sequencer.sv
// Block-write front end for KFMMC_DRIVE: turns a start/address request and a byte stream
// into the drive's address/command/data strobe sequence, with byte-count and timeout checks.
module kfmmc_block_write_sequencer #(
    parameter logic [7:0]  WRITE_COMMAND  = 8'h81,
    parameter int unsigned BLOCK_BYTES    = 512,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] block_address,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  data_bus,
    output logic        write_block_address_1,
    output logic        write_block_address_2,
    output logic        write_block_address_3,
    output logic        write_block_address_4,
    output logic        write_command,
    output logic        write_data,
    output logic        read_data,
    input  logic        drive_busy,
    input  logic        write_interface_error,
    input  logic        request_write_data_interrupt,
    input  logic        write_completion_interrupt
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned TMR_W  = 24;

    localparam logic [CNT_W-1:0] BLOCK_LAST   = CNT_W'(BLOCK_BYTES);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - TMR_W'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_READY,
        S_ADDR1,
        S_ADDR2,
        S_ADDR3,
        S_ADDR4,
        S_CMD,
        S_WAIT_IRQ,
        S_SEND,
        S_RESULT,
        S_WAIT_BUSY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic              wr_ready_c;
    logic              timed_c;
    logic              timeout_c;

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            byte_q  <= '0;
            count_q <= '0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
            count_q <= count_d;
            timer_q <= timer_d;
            busy_q  <= busy_d;
            error_q <= error_d;
        end
    end

    // Next-state, counters and stream handshake
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_d     = byte_q;
        count_d    = count_q;
        busy_d     = busy_q;
        error_d    = error_q;
        wr_ready_c = 1'b0;
        timed_c    = (state_q == S_WAIT_IRQ) || (state_q == S_SEND) || (state_q == S_WAIT_BUSY);
        timeout_c  = timed_c && (timer_q == TIMEOUT_LAST);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = block_address;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_WAIT_READY;
                end
            end
            S_WAIT_READY: begin
                if (!drive_busy) begin
                    state_d = S_ADDR1;
                end
            end
            S_ADDR1: state_d = S_ADDR2;
            S_ADDR2: state_d = S_ADDR3;
            S_ADDR3: state_d = S_ADDR4;
            S_ADDR4: state_d = S_CMD;
            S_CMD: begin
                count_d = '0;
                state_d = S_WAIT_IRQ;
            end
            S_WAIT_IRQ: begin
                if (write_interface_error) begin
                    state_d = S_ERROR;
                end else if (write_completion_interrupt) begin
                    state_d = (count_q == BLOCK_LAST) ? S_RESULT : S_ERROR;
                end else if (request_write_data_interrupt) begin
                    if (count_q == BLOCK_LAST) begin
                        state_d = S_ERROR;
                    end else begin
                        wr_ready_c = 1'b1;
                        if (wr_valid) begin
                            byte_d  = wr_data;
                            count_d = count_q + CNT_W'(1);
                            state_d = S_SEND;
                        end
                    end
                end
            end
            S_SEND: begin
                if (write_interface_error) begin
                    state_d = S_ERROR;
                end else if (!request_write_data_interrupt) begin
                    state_d = S_WAIT_IRQ;
                end
            end
            S_RESULT: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!drive_busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Timeout overrides everything, including a byte that would have been accepted
        if (timeout_c) begin
            state_d    = S_ERROR;
            wr_ready_c = 1'b0;
            byte_d     = byte_q;
            count_d    = count_q;
        end

        if ((state_d == S_ERROR) && (state_q != S_ERROR)) begin
            error_d = 1'b1;
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timed_c) begin
            timer_d = timer_q + TMR_W'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    // Drive strobes decode directly from the registered state
    always_comb begin
        data_bus = '0;
        case (state_q)
            S_ADDR1: data_bus = addr_q[7:0];
            S_ADDR2: data_bus = addr_q[15:8];
            S_ADDR3: data_bus = addr_q[23:16];
            S_ADDR4: data_bus = addr_q[31:24];
            S_CMD:   data_bus = WRITE_COMMAND;
            S_SEND:  data_bus = byte_q;
            default: data_bus = '0;
        endcase
    end

    assign write_block_address_1 = (state_q == S_ADDR1);
    assign write_block_address_2 = (state_q == S_ADDR2);
    assign write_block_address_3 = (state_q == S_ADDR3);
    assign write_block_address_4 = (state_q == S_ADDR4);
    assign write_command         = (state_q == S_CMD);
    assign write_data            = (state_q == S_SEND);
    assign read_data             = (state_q == S_RESULT) || (state_q == S_ERROR);
    assign done                  = (state_q == S_DONE);
    assign busy                  = busy_q;
    assign error                 = error_q;
    assign wr_ready              = wr_ready_c;

endmodule
